// File: rtl/pipelined_adder_tree.sv
// pipelined_adder_tree: reduces NUM_OPS unsigned operands through registered 3:2 CSA levels,
// a registered CPA and a frame accumulator. Define ADDER_TREE_SAT_EN for saturating arithmetic.
module pipelined_adder_tree #(
   parameter int unsigned WIDTH   = 13,
   parameter int unsigned NUM_OPS = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [NUM_OPS*WIDTH-1:0]   in_ops,
   input  logic                       in_last,
   input  logic                       acc_mode,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           out_sum,
   output logic                       out_ovf
);

   // Operand count remaining after lv 3:2 levels (each full triple becomes a sum/carry pair).
   function automatic int ops_after(input int lv);
      int n;
      n = int'(NUM_OPS);
      for (int i = 0; i < lv; i++) n = n - n / 3;
      return n;
   endfunction

   function automatic int num_levels();
      int n;
      int l;
      n = int'(NUM_OPS);
      l = 0;
      while (n > 2) begin
         n = n - n / 3;
         l++;
      end
      return l;
   endfunction

   localparam int unsigned L  = num_levels();
   // Two spare slots keep every pass-through index in range for all operand counts.
   localparam int unsigned NS = NUM_OPS + 2;
`ifdef ADDER_TREE_SAT_EN
   localparam int unsigned IW = WIDTH + $clog2(NUM_OPS);
`else
   localparam int unsigned IW = WIDTH;
`endif

   logic                 w_stall;
   logic [IW-1:0]        r_st   [0:L][NS];
   logic                 r_vld  [0:L];
   logic                 r_mode [0:L];
   logic                 r_last [0:L];
   logic [IW-1:0]        w_lvl  [1:L][NS];

   logic [IW-1:0]        w_cpa_full;
   logic [WIDTH-1:0]     w_cpa_res;
   logic                 w_cpa_ovf;
   logic [WIDTH-1:0]     r_cpa;
   logic                 r_cpa_vld;
   logic                 r_cpa_mode;
   logic                 r_cpa_last;
   logic                 r_cpa_ovf;

   logic [WIDTH-1:0]     w_acc_next;
   logic                 w_acc_ovf;
   logic [WIDTH-1:0]     r_acc;
   logic                 r_acc_ovf;
   logic [WIDTH-1:0]     r_out_sum;
   logic                 r_out_valid;
   logic                 r_out_ovf;

   // A held result freezes the whole pipeline; bubbles are not squeezed out.
   assign w_stall   = r_out_valid && !out_ready;
   assign in_ready  = !w_stall;
   assign out_valid = r_out_valid;
   assign out_sum   = r_out_sum;
   assign out_ovf   = r_out_ovf;

   // One 3:2 level per stage: triples compress to sum + shifted carry, leftovers pass through.
   always_comb begin
      for (int lv = 1; lv <= int'(L); lv++) begin
         for (int j = 0; j < int'(NS); j++) w_lvl[lv][j] = '0;
         for (int g = 0; g < int'(NUM_OPS) / 3; g++) begin
            if (g < ops_after(lv - 1) / 3) begin
               w_lvl[lv][2*g]   = r_st[lv-1][3*g] ^ r_st[lv-1][3*g+1] ^ r_st[lv-1][3*g+2];
               w_lvl[lv][2*g+1] = ((r_st[lv-1][3*g]   & r_st[lv-1][3*g+1]) |
                                   (r_st[lv-1][3*g]   & r_st[lv-1][3*g+2]) |
                                   (r_st[lv-1][3*g+1] & r_st[lv-1][3*g+2])) << 1;
            end
         end
         for (int k = 0; k < 2; k++) begin
            if (k < ops_after(lv - 1) - 3 * (ops_after(lv - 1) / 3)) begin
               w_lvl[lv][2*(ops_after(lv - 1) / 3) + k] = r_st[lv-1][3*(ops_after(lv - 1) / 3) + k];
            end
         end
      end
   end

   // Input capture stage followed by the CSA level registers, with sidebands riding along.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s <= int'(L); s++) begin
            r_vld[s]  <= 1'b0;
            r_mode[s] <= 1'b0;
            r_last[s] <= 1'b0;
            for (int j = 0; j < int'(NS); j++) r_st[s][j] <= '0;
         end
      end else if (!w_stall) begin
         r_vld[0]  <= in_valid;
         r_mode[0] <= acc_mode;
         r_last[0] <= in_last;
         for (int j = 0; j < int'(NUM_OPS); j++) r_st[0][j] <= IW'(in_ops[j*WIDTH +: WIDTH]);
         for (int j = int'(NUM_OPS); j < int'(NS); j++) r_st[0][j] <= '0;
         for (int s = 1; s <= int'(L); s++) begin
            r_vld[s]  <= r_vld[s-1];
            r_mode[s] <= r_mode[s-1];
            r_last[s] <= r_last[s-1];
            for (int j = 0; j < int'(NS); j++) r_st[s][j] <= w_lvl[s][j];
         end
      end
   end

   assign w_cpa_full = r_st[L][0] + r_st[L][1];

`ifdef ADDER_TREE_SAT_EN
   logic [WIDTH:0] w_acc_full;

   // Wide tree result clamps to the largest WIDTH-bit value.
   always_comb begin
      w_cpa_ovf  = |w_cpa_full[IW-1:WIDTH];
      w_cpa_res  = w_cpa_ovf ? '1 : w_cpa_full[WIDTH-1:0];
      w_acc_full = {1'b0, r_acc} + {1'b0, r_cpa};
      w_acc_ovf  = w_acc_full[WIDTH];
      w_acc_next = w_acc_ovf ? '1 : w_acc_full[WIDTH-1:0];
   end
`else
   assign w_cpa_ovf  = 1'b0;
   assign w_cpa_res  = w_cpa_full;
   assign w_acc_ovf  = 1'b0;
   assign w_acc_next = r_acc + r_cpa;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cpa      <= '0;
         r_cpa_vld  <= 1'b0;
         r_cpa_mode <= 1'b0;
         r_cpa_last <= 1'b0;
         r_cpa_ovf  <= 1'b0;
      end else if (!w_stall) begin
         r_cpa      <= w_cpa_res;
         r_cpa_vld  <= r_vld[L];
         r_cpa_mode <= r_mode[L];
         r_cpa_last <= r_last[L];
         r_cpa_ovf  <= w_cpa_ovf;
      end
   end

   // Output stage: per-beat results pass straight out, frame beats fold into the accumulator.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_sum   <= '0;
         r_out_ovf   <= 1'b0;
         r_acc       <= '0;
         r_acc_ovf   <= 1'b0;
      end else if (!w_stall) begin
         r_out_valid <= 1'b0;
         if (r_cpa_vld) begin
            if (!r_cpa_mode) begin
               r_out_valid <= 1'b1;
               r_out_sum   <= r_cpa;
               r_out_ovf   <= r_cpa_ovf;
            end else if (r_cpa_last) begin
               r_out_valid <= 1'b1;
               r_out_sum   <= w_acc_next;
               r_out_ovf   <= r_acc_ovf | r_cpa_ovf | w_acc_ovf;
               r_acc       <= '0;
               r_acc_ovf   <= 1'b0;
            end else begin
               r_acc       <= w_acc_next;
               r_acc_ovf   <= r_acc_ovf | r_cpa_ovf | w_acc_ovf;
            end
         end
      end
   end

endmodule

// File: tb/tb_pipelined_adder_tree.sv
// Self-checking bench for pipelined_adder_tree: transaction-level sum/frame model with an
// ordered expectation queue, latency accounting and directed literal cases.
module tb_pipelined_adder_tree;
   localparam int unsigned W    = 13;
   localparam int unsigned N    = 4;
   localparam int unsigned OPW  = W * N;
   localparam longint      MAXV = (64'sd1 <<< W) - 1;

   function automatic int spec_levels(input int n);
      if (n <= 3) return 1;
      if (n == 4) return 2;
      if (n <= 6) return 3;
      if (n <= 9) return 4;
      if (n <= 13) return 5;
      return 6;
   endfunction

   localparam int LAT = spec_levels(int'(N)) + 2;

   typedef struct {
      longint sum;
      bit     ovf;
      int     pin;
      longint acc_edge;
      int     stalls;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [OPW-1:0]  in_ops = '0;
   logic            in_last = 1'b0;
   logic            acc_mode = 1'b0;
   logic            out_valid;
   logic            out_ready = 1'b1;
   logic [W-1:0]    out_sum;
   logic            out_ovf;

   logic            s8_valid = 1'b0, s8_ready, s8_ovalid, s8_ovf;
   logic [127:0]    s8_ops = '0;
   logic [15:0]     s8_sum;
   logic            s3_valid = 1'b0, s3_ready, s3_ovalid, s3_ovf;
   logic [38:0]     s3_ops = '0;
   logic [12:0]     s3_sum;

   int     checks = 0;
   int     errors = 0;
   longint cyc = 0;
   int     stall_cnt = 0;
   bit     prev_stall = 0;
   logic [W-1:0] prev_sum = '0;
   longint m_acc = 0;
   bit     m_acc_ovf = 0;
   bit     frame_open = 0;
   exp_t   q[$];

   pipelined_adder_tree #(.WIDTH(W), .NUM_OPS(N)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_ops(in_ops),
      .in_last(in_last), .acc_mode(acc_mode), .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_ovf(out_ovf));

   pipelined_adder_tree #(.WIDTH(16), .NUM_OPS(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(s8_valid), .in_ready(s8_ready), .in_ops(s8_ops),
      .in_last(1'b0), .acc_mode(1'b0), .out_valid(s8_ovalid), .out_ready(1'b1),
      .out_sum(s8_sum), .out_ovf(s8_ovf));

   pipelined_adder_tree #(.WIDTH(13), .NUM_OPS(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .in_valid(s3_valid), .in_ready(s3_ready), .in_ops(s3_ops),
      .in_last(1'b0), .acc_mode(1'b0), .out_valid(s3_ovalid), .out_ready(1'b1),
      .out_sum(s3_sum), .out_ovf(s3_ovf));

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #400000;
      $display("FAIL watchdog actual=running expected=finished at cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at cycle %0d", name, act, exp, cyc);
      end
   endtask

   function automatic logic [OPW-1:0] pack4(input int a, input int b, input int c, input int d);
      logic [OPW-1:0] v;
      v = {W'(d), W'(c), W'(b), W'(a)};
      return v;
   endfunction

   function automatic longint fit(input longint s, inout bit ov);
`ifdef ADDER_TREE_SAT_EN
      if (s > MAXV) begin
         ov = 1'b1;
         return MAXV;
      end
      return s;
`else
      return s % (MAXV + 1);
`endif
   endfunction

   // Beat-level reference: plain sum, then per-beat or per-frame output.
   task automatic model_accept(input logic [OPW-1:0] ops, input bit md, input bit lst, input int pin);
      longint s;
      bit     ov;
      exp_t   e;
      s  = 0;
      ov = 1'b0;
      for (int k = 0; k < int'(N); k++) s += longint'(ops[k*W +: W]);
      s = fit(s, ov);
      if (md) begin
         s  = fit(s + m_acc, ov);
         ov = ov | m_acc_ovf;
         if (!lst) begin
            m_acc      = s;
            m_acc_ovf  = ov;
            frame_open = 1'b1;
            return;
         end
         m_acc      = 0;
         m_acc_ovf  = 1'b0;
         frame_open = 1'b0;
      end
      e.sum      = s;
      e.ovf      = ov;
      e.pin      = pin;
      e.acc_edge = cyc + 1;
      e.stalls   = stall_cnt;
      q.push_back(e);
   endtask

   // One cycle: drive at the falling edge, then compare and account for the coming rising edge.
   task automatic step(input bit v, input logic [OPW-1:0] ops, input bit md, input bit lst,
                       input bit ordy, input int pin, output bit accepted);
      bit   stall_now;
      exp_t e;
      @(negedge clk);
      in_valid = v; in_ops = ops; acc_mode = md; in_last = lst; out_ready = ordy;
      #1;
      stall_now = out_valid && !out_ready;
      chk("in_ready", longint'(in_ready), longint'(!stall_now));
      if (prev_stall) chk("stall_hold_sum", longint'(out_sum), longint'(prev_sum));
      if (out_valid) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_output actual=out_valid_1_sum_%0d expected=no_output at cycle %0d",
                     out_sum, cyc);
         end else begin
            e = q[0];
            chk("out_sum", longint'(out_sum), e.sum);
            chk("out_ovf", longint'(out_ovf), longint'(e.ovf));
            if (e.pin >= 0) chk("literal_sum", longint'(out_sum), longint'(e.pin));
            if (!prev_stall) chk("latency", cyc - e.acc_edge, longint'(LAT + stall_cnt - e.stalls));
            if (out_ready) void'(q.pop_front());
         end
      end
      accepted = v && in_ready;
      if (accepted) model_accept(ops, md, lst, pin);
      if (stall_now) stall_cnt++;
      prev_stall = stall_now;
      prev_sum   = out_sum;
   endtask

   task automatic idle(input int n);
      bit a;
      for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b1, -1, a);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      #1;
      chk("rst_out_valid", longint'(out_valid), 0);
      chk("rst_out_sum", longint'(out_sum), 0);
      chk("rst_out_ovf", longint'(out_ovf), 0);
      q.delete();
      m_acc = 0; m_acc_ovf = 1'b0; frame_open = 1'b0; prev_stall = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_in_ready", longint'(in_ready), 1);
   endtask

   initial begin
      bit a;
      bit v, md, lst, ordy, found;
      int idx, bp_cnt;
      bit bp_started;
      logic [OPW-1:0] ops;
      logic [OPW-1:0] bp [6];

      do_reset();

      // Basic per-beat sum.
      step(1'b1, pack4(1, 2, 3, 4), 1'b0, 1'b0, 1'b1, 10, a);
      idle(6);

      // All-ones operands: wrap or clamp.
`ifdef ADDER_TREE_SAT_EN
      step(1'b1, pack4(8191, 8191, 8191, 8191), 1'b0, 1'b0, 1'b1, 8191, a);
`else
      step(1'b1, pack4(8191, 8191, 8191, 8191), 1'b0, 1'b0, 1'b1, 8188, a);
`endif
      idle(6);

      // Backpressure: six distinct beats, out_ready low for 3 cycles once a result shows.
      for (int i = 0; i < 6; i++) bp[i] = pack4(i + 1, 2 * i + 3, 100 * i, 7);
      idx = 0; bp_cnt = 0; bp_started = 1'b0;
      for (int t = 0; t < 40; t++) begin
         if (idx == 6 && q.size() == 0 && !out_valid) break;
         step(idx < 6, (idx < 6) ? bp[idx] : '0, 1'b0, 1'b0, bp_cnt == 0, -1, a);
         if (a) idx++;
         if (bp_cnt > 0) bp_cnt--;
         else if (!bp_started && out_valid) begin
            bp_started = 1'b1;
            bp_cnt = 3;
         end
      end
      chk("bp_all_accepted", idx, 6);
      chk("bp_all_emitted", q.size(), 0);

      // Frame accumulation then a per-beat result.
      step(1'b1, pack4(1, 1, 1, 1), 1'b1, 1'b0, 1'b1, -1, a);
      step(1'b1, pack4(1, 1, 1, 1), 1'b1, 1'b0, 1'b1, -1, a);
      step(1'b1, pack4(1, 1, 1, 1), 1'b1, 1'b1, 1'b1, 12, a);
      step(1'b1, pack4(5, 0, 0, 0), 1'b0, 1'b0, 1'b1, 5, a);
      idle(8);

      // Reset with a partial frame in flight.
      step(1'b1, pack4(3, 3, 3, 3), 1'b1, 1'b0, 1'b1, -1, a);
      step(1'b1, pack4(3, 3, 3, 3), 1'b1, 1'b0, 1'b1, -1, a);
      do_reset();
      idle(6);
      step(1'b1, pack4(2, 2, 2, 2), 1'b1, 1'b1, 1'b1, 8, a);
      idle(6);

      // Randomized traffic with frames and backpressure.
      for (int t = 0; t < 400; t++) begin
         v = ($urandom_range(0, 3) != 0);
         for (int k = 0; k < int'(N); k++) begin
            if ($urandom_range(0, 1) == 0) ops[k*W +: W] = W'($urandom);
            else ops[k*W +: W] = W'($urandom_range(0, 20));
         end
         md   = frame_open ? 1'b1 : 1'($urandom_range(0, 1));
         lst  = ($urandom_range(0, 2) == 0);
         ordy = ($urandom_range(0, 3) != 0);
         step(v, ops, md, lst, ordy, -1, a);
      end
      for (int t = 0; t < 60; t++) begin
         if (q.size() == 0 && !out_valid) break;
         step(1'b0, '0, 1'b0, 1'b0, 1'b1, -1, a);
      end
      chk("drain_pending", q.size(), 0);

      // NUM_OPS=8, WIDTH=16: 1..8.
      @(negedge clk);
      for (int k = 0; k < 8; k++) s8_ops[k*16 +: 16] = 16'(k + 1);
      s8_valid = 1'b1;
      #1;
      chk("g8_in_ready", longint'(s8_ready), 1);
      found = 1'b0;
      for (int i = 1; i <= 20 && !found; i++) begin
         @(negedge clk);
         s8_valid = 1'b0;
         #1;
         if (s8_ovalid) begin
            found = 1'b1;
            chk("g8_latency", i - 1, 6);
            chk("g8_sum", longint'(s8_sum), 36);
            chk("g8_ovf", longint'(s8_ovf), 0);
         end
      end
      chk("g8_found", longint'(found), 1);

      // NUM_OPS=3, WIDTH=13: {7,8,9}.
      @(negedge clk);
      s3_ops = {13'd9, 13'd8, 13'd7};
      s3_valid = 1'b1;
      #1;
      chk("g3_in_ready", longint'(s3_ready), 1);
      found = 1'b0;
      for (int i = 1; i <= 20 && !found; i++) begin
         @(negedge clk);
         s3_valid = 1'b0;
         #1;
         if (s3_ovalid) begin
            found = 1'b1;
            chk("g3_latency", i - 1, 3);
            chk("g3_sum", longint'(s3_sum), 24);
            chk("g3_ovf", longint'(s3_ovf), 0);
         end
      end
      chk("g3_found", longint'(found), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
